// File: rtl/as_pack.sv
// Shared types and constants for the as_fetch_ctrl instruction-fetch sequencer.
package as_pack;
    localparam int IADDR_WIDTH = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        KILL
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]            instr;
        logic [IADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

    function automatic logic [IADDR_WIDTH-1:0] pc_step(input logic [IADDR_WIDTH-1:0] pc);
        return pc + IADDR_WIDTH'(INSTR_BYTES);
    endfunction
endpackage

// File: rtl/as_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the imem req/ack handshake and buffers one
// instruction plus a skid entry toward decode. FETCH_MISALIGN_EN traps misaligned redirects.
module as_fetch_ctrl
    import as_pack::*;
#(
    parameter logic [IADDR_WIDTH-1:0] RESET_VEC = '0,
    parameter logic [IADDR_WIDTH-1:0] TRAP_VEC  = IADDR_WIDTH'('h100)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [IADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                   trap_i,
    output logic                   imem_req_o,
    output logic [IADDR_WIDTH-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [31:0]            imem_rdata_i,
    output logic                   instr_valid_o,
    output logic [31:0]            instr_o,
    output logic [IADDR_WIDTH-1:0] instr_pc_o,
    output logic                   flush_o,
    output logic                   misalign_o
);
    fetch_state_t           state_reg, state_next;
    logic [IADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [IADDR_WIDTH-1:0] kill_addr_reg, kill_addr_next;
    fetch_entry_t           buf_reg, buf_next;
    fetch_entry_t           skid_reg, skid_next;
    logic                   valid_reg, valid_next;
    logic                   skid_valid_reg, skid_valid_next;
    logic                   flush_reg, misalign_reg;

    logic                   change_flow, misalign_hit;
    logic [IADDR_WIDTH-1:0] redirect_target, flow_target;
    fetch_entry_t           fetched;

`ifdef FETCH_MISALIGN_EN
    assign misalign_hit    = redirect_i && !trap_i && (redirect_pc_i[1:0] != 2'b00);
    assign redirect_target = misalign_hit ? TRAP_VEC : redirect_pc_i;
`else
    // Without misalign detection the target is simply word-aligned.
    assign misalign_hit    = 1'b0;
    assign redirect_target = {redirect_pc_i[IADDR_WIDTH-1:2], redirect_pc_i[1:0] & 2'b00};
`endif

    assign change_flow   = trap_i || redirect_i;
    assign flow_target   = trap_i ? TRAP_VEC : redirect_target;
    assign fetched.instr = imem_rdata_i;
    assign fetched.pc    = pc_reg;

    // KILL keeps presenting the abandoned address so the open request stays stable until ack.
    assign imem_req_o    = (state_reg == REQ) || (state_reg == KILL);
    assign imem_addr_o   = (state_reg == KILL) ? kill_addr_reg : pc_reg;
    assign instr_valid_o = valid_reg;
    assign instr_o       = buf_reg.instr;
    assign instr_pc_o    = buf_reg.pc;
    assign flush_o       = flush_reg;
    assign misalign_o    = misalign_reg;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        kill_addr_next  = kill_addr_reg;
        buf_next        = buf_reg;
        skid_next       = skid_reg;
        valid_next      = valid_reg;
        skid_valid_next = skid_valid_reg;

        if (change_flow) begin
            pc_next         = flow_target;
            valid_next      = 1'b0;
            skid_valid_next = 1'b0;
            skid_next       = '0;
            case (state_reg)
                REQ: begin
                    if (!imem_ack_i) begin
                        state_next     = KILL;
                        kill_addr_next = pc_reg;
                    end else begin
                        state_next = REQ;
                    end
                end
                KILL:    state_next = imem_ack_i ? REQ : KILL;
                default: state_next = REQ;
            endcase
        end else begin
            if (valid_reg && !stall_i) begin
                valid_next = 1'b0;
            end
            case (state_reg)
                IDLE: state_next = REQ;
                REQ: begin
                    if (imem_ack_i) begin
                        pc_next = pc_step(pc_reg);
                        if (!valid_reg || !stall_i) begin
                            buf_next   = fetched;
                            valid_next = 1'b1;
                        end else begin
                            skid_next       = fetched;
                            skid_valid_next = 1'b1;
                            state_next      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Decode takes the buffer this cycle, so the skid entry slides in behind it.
                    if (!stall_i) begin
                        buf_next        = skid_reg;
                        valid_next      = skid_valid_reg;
                        skid_next       = '0;
                        skid_valid_next = 1'b0;
                        state_next      = REQ;
                    end
                end
                KILL: begin
                    if (imem_ack_i) begin
                        state_next = REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_VEC;
            kill_addr_reg  <= RESET_VEC;
            buf_reg        <= '0;
            skid_reg       <= '0;
            valid_reg      <= 1'b0;
            skid_valid_reg <= 1'b0;
            flush_reg      <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            kill_addr_reg  <= kill_addr_next;
            buf_reg        <= buf_next;
            skid_reg       <= skid_next;
            valid_reg      <= valid_next;
            skid_valid_reg <= skid_valid_next;
            flush_reg      <= change_flow;
            misalign_reg   <= misalign_hit;
        end
    end
endmodule

// File: tb/tb_as_fetch_ctrl.sv
// Bench for as_fetch_ctrl: directed scenarios plus a randomized run scored against a
// queue model of the fetch stream. Expectations follow FETCH_MISALIGN_EN when defined.
module tb_as_fetch_ctrl;
    import as_pack::*;

    localparam logic [IADDR_WIDTH-1:0] RVEC = '0;
    localparam logic [IADDR_WIDTH-1:0] TVEC = 32'h100;
`ifdef FETCH_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        logic [IADDR_WIDTH-1:0] pc;
        logic [31:0]            instr;
    } entry_t;

    logic                   clk = 1'b0;
    logic                   rst, stall, redirect, trap, ack;
    logic                   req, valid, flush, misalign;
    logic [IADDR_WIDTH-1:0] redirect_pc, addr, ipc;
    logic [31:0]            rdata, instr;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [IADDR_WIDTH-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rdata = mem_word(addr);

    as_fetch_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .trap_i       (trap),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_ack_i   (ack),
        .imem_rdata_i (rdata),
        .instr_valid_o(valid),
        .instr_o      (instr),
        .instr_pc_o   (ipc),
        .flush_o      (flush),
        .misalign_o   (misalign)
    );

    // Leaves the DUT in its first REQ cycle at RVEC.
    task automatic do_reset();
        rst = 1'b1; ack = 1'b0; stall = 1'b0; redirect = 1'b0; trap = 1'b0; redirect_pc = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ack = 1'b1; stall = 1'b0; redirect = 1'b0; trap = 1'b0; redirect_pc = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req, valid, flush, misalign, instr, ipc, addr} !== {4'b0000, 32'h0, RVEC, RVEC}) begin
            errors++;
            $display("FAIL reset_state: got req=%b valid=%b flush=%b mis=%b instr=%h pc=%h addr=%h, want all zero",
                     req, valid, flush, misalign, instr, ipc, addr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req, addr, valid} !== {1'b1, RVEC, 1'b0}) begin
            errors++;
            $display("FAIL idle_one_cycle: got req=%b addr=%h valid=%b, want req=1 addr=%h valid=0", req, addr, valid, RVEC);
        end
        $display("reset: state cleared, first request after one idle cycle");
    endtask

    task automatic test_stream();
        logic [IADDR_WIDTH-1:0] a;
        do_reset();
        ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a = IADDR_WIDTH'(4 * k);
            checks++;
            if ({req, addr} !== {1'b1, a}) begin
                errors++;
                $display("FAIL stream_addr[%0d]: got req=%b addr=%h, want req=1 addr=%h", k, req, addr, a);
            end
            checks++;
            if (k == 0 ? (valid !== 1'b0) : ({valid, ipc, instr} !== {1'b1, a - 32'd4, mem_word(a - 32'd4)})) begin
                errors++;
                $display("FAIL stream_buf[%0d]: got valid=%b pc=%h instr=%h, want pc=%h", k, valid, ipc, instr, a - 32'd4);
            end
            @(negedge clk);
        end
        $display("stream: addresses 0..10 issued back to back");
    endtask

    task automatic test_hold();
        do_reset();
        ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({addr, ipc} !== {32'h8, 32'h4}) begin
            errors++;
            $display("FAIL hold_setup: got addr=%h pc=%h, want addr=8 pc=4", addr, ipc);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({req, valid, ipc} !== {1'b0, 1'b1, 32'h4}) begin
                errors++;
                $display("FAIL hold_stall[%0d]: got req=%b valid=%b pc=%h, want req=0 valid=1 pc=4", i, req, valid, ipc);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, ipc, instr, req, addr} !== {1'b1, 32'h8, mem_word(32'h8), 1'b1, 32'hC}) begin
            errors++;
            $display("FAIL hold_release: got valid=%b pc=%h instr=%h req=%b addr=%h, want pc=8 req=1 addr=c",
                     valid, ipc, instr, req, addr);
        end
        @(negedge clk);
        checks++;
        if ({valid, ipc, instr} !== {1'b1, 32'hC, mem_word(32'hC)}) begin
            errors++;
            $display("FAIL hold_next: got valid=%b pc=%h instr=%h, want pc=c", valid, ipc, instr);
        end
        $display("hold: skid entry delivered after 3 stall cycles");
    endtask

    task automatic test_kill();
        do_reset();
        ack = 1'b1;
        repeat (4) @(negedge clk);
        ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({req, addr} !== {1'b1, 32'h10}) begin
                errors++;
                $display("FAIL kill_wait[%0d]: got req=%b addr=%h, want req=1 addr=10", i, req, addr);
            end
            @(negedge clk);
        end
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({req, addr, flush, valid} !== {1'b1, 32'h10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL kill_hold: got req=%b addr=%h flush=%b valid=%b, want req=1 addr=10 flush=1 valid=0",
                     req, addr, flush, valid);
        end
        ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({req, addr, flush, valid} !== {1'b1, 32'h200, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL kill_done: got req=%b addr=%h flush=%b valid=%b, want req=1 addr=200 flush=0 valid=0",
                     req, addr, flush, valid);
        end
        @(negedge clk);
        checks++;
        if ({valid, ipc, instr, flush} !== {1'b1, 32'h200, mem_word(32'h200), 1'b0}) begin
            errors++;
            $display("FAIL kill_target: got valid=%b pc=%h instr=%h flush=%b, want pc=200", valid, ipc, instr, flush);
        end
        $display("kill: stale fetch at 10 dropped, refetch from 200");
    endtask

    task automatic test_trap_priority();
        do_reset();
        ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        trap = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        trap = 1'b0; redirect = 1'b0;
        checks++;
        if ({flush, valid, req, addr} !== {1'b1, 1'b0, 1'b1, TVEC}) begin
            errors++;
            $display("FAIL trap_target: got flush=%b valid=%b req=%b addr=%h, want flush=1 valid=0 addr=%h",
                     flush, valid, req, addr, TVEC);
        end
        @(negedge clk);
        checks++;
        if ({flush, valid, ipc, addr} !== {1'b0, 1'b1, TVEC, TVEC + 32'd4}) begin
            errors++;
            $display("FAIL trap_single_flush: got flush=%b valid=%b pc=%h addr=%h, want flush=0 pc=%h",
                     flush, valid, ipc, addr, TVEC);
        end
        $display("trap: trap outranks redirect, single flush");
    endtask

    task automatic test_misalign();
        do_reset();
        ack = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h202;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({flush, misalign, req, addr, valid} !== {1'b1, MIS_EN, 1'b1, (MIS_EN ? TVEC : 32'h200), 1'b0}) begin
            errors++;
            $display("FAIL misalign_redirect: got flush=%b mis=%b req=%b addr=%h valid=%b, want mis=%b",
                     flush, misalign, req, addr, valid, MIS_EN);
        end
        @(negedge clk);
        checks++;
        if ({flush, misalign} !== 2'b00) begin
            errors++;
            $display("FAIL misalign_pulse: got flush=%b mis=%b, want 0 0", flush, misalign);
        end
        $display("misalign: redirect to 202 handled");
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        ack = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if ({req, addr} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL rst_mid_setup: got req=%b addr=%h, want req=1 addr=40", req, addr);
        end
        ack = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({req, addr, valid} !== {1'b0, RVEC, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_req: got req=%b addr=%h valid=%b, want req=0 addr=%h valid=0", req, addr, valid, RVEC);
        end
        $display("reset_mid_req: request abandoned");
    endtask

    task automatic test_random();
        entry_t                 q[$];
        logic [IADDR_WIDTH-1:0] mpc, paddr;
        bit                     discard, pwait, in_idle, eflush, emis;
        do_reset();
        mpc = RVEC; paddr = RVEC;
        discard = 1'b0; pwait = 1'b0; in_idle = 1'b0; eflush = 1'b0; emis = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            checks++;
            if (valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid@%0d: got %b, want %b", n, valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({ipc, instr} !== {q[0].pc, q[0].instr}) begin
                    errors++;
                    $display("FAIL rand_instr@%0d: got pc=%h instr=%h, want pc=%h instr=%h", n, ipc, instr, q[0].pc, q[0].instr);
                end
            end
            checks++;
            if ({flush, misalign} !== {eflush, emis}) begin
                errors++;
                $display("FAIL rand_flush@%0d: got flush=%b mis=%b, want %b %b", n, flush, misalign, eflush, emis);
            end
            checks++;
            if (req !== (!in_idle && q.size() < 2)) begin
                errors++;
                $display("FAIL rand_req@%0d: got %b, want %b", n, req, !in_idle && q.size() < 2);
            end
            if (pwait) begin
                checks++;
                if (addr !== paddr) begin
                    errors++;
                    $display("FAIL rand_stable_addr@%0d: got %h, want %h", n, addr, paddr);
                end
            end
            if (req && !discard) begin
                checks++;
                if (addr !== mpc) begin
                    errors++;
                    $display("FAIL rand_addr@%0d: got %h, want %h", n, addr, mpc);
                end
            end

            rst      = ($urandom_range(0, 199) == 0);
            stall    = ($urandom_range(0, 9) < 4);
            ack      = ($urandom_range(0, 9) < 6);
            redirect = ($urandom_range(0, 19) == 0);
            trap     = ($urandom_range(0, 49) == 0);
            redirect_pc = IADDR_WIDTH'($urandom_range(0, 32'hFFFF));
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;

            if (rst) begin
                q.delete();
                mpc = RVEC; discard = 1'b0; pwait = 1'b0; in_idle = 1'b1; eflush = 1'b0; emis = 1'b0;
            end else begin
                in_idle = 1'b0;
                eflush  = redirect || trap;
                emis    = MIS_EN && redirect && !trap && (redirect_pc[1:0] != 2'b00);
                if (redirect || trap) begin
                    q.delete();
                    mpc     = (trap || emis) ? TVEC : {redirect_pc[IADDR_WIDTH-1:2], 2'b00};
                    discard = req && !ack;
                end else begin
                    if (q.size() != 0 && !stall) begin
                        $display("consume pc=%h instr=%h", q[0].pc, q[0].instr);
                        q.delete(0);
                    end
                    if (req && ack) begin
                        if (discard) begin
                            discard = 1'b0;
                        end else begin
                            q.push_back('{pc: mpc, instr: mem_word(mpc)});
                            mpc = mpc + 32'd4;
                        end
                    end
                end
                pwait = req && !ack;
                paddr = addr;
            end
            @(negedge clk);
        end
        $display("random: 1200 cycles scored");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_kill();
        test_trap_priority();
        test_misalign();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
